// File: rtl/wash_pkg.sv
// Shared encodings for the washer sequencer: state codes, error codes and the
// program-select to total-time table.
package wash_pkg;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_OPTIONS = 4'd1;
  localparam logic [3:0] ST_CONFIG  = 4'd2;
  localparam logic [3:0] ST_READY   = 4'd3;
  localparam logic [3:0] ST_WASH    = 4'd4;
  localparam logic [3:0] ST_RINSE   = 4'd5;
  localparam logic [3:0] ST_DRAIN   = 4'd6;
  localparam logic [3:0] ST_DRY     = 4'd7;
  localparam logic [3:0] ST_DONE    = 4'd8;
  localparam logic [3:0] ST_FILL    = 4'd9;
  localparam logic [3:0] ST_PAUSED  = 4'd10;
  localparam logic [3:0] ST_CHECK   = 4'd15;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_DOOR   = 2'd1,
    ERR_WATER  = 2'd2,
    ERR_MANUAL = 2'd3
  } err_e;

  function automatic logic [15:0] mode_time(input logic [2:0] sel);
    case (sel)
      3'd1:    mode_time = 16'd190;
      3'd2:    mode_time = 16'd140;
      3'd3:    mode_time = 16'd160;
      3'd4:    mode_time = 16'd150;
      3'd5:    mode_time = 16'd230;
      default: mode_time = 16'd120;
    endcase
  endfunction

endpackage

// File: rtl/wash_tick_gen.sv
// Timebase prescaler: one tick every PRESCALE clocks, restarted whenever the
// controller is unpowered so the first tick lands right after power-up.
module wash_tick_gen #(
  parameter int PRESCALE = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)              cnt_d = '0;
    else if (cnt_q == '0)   cnt_d = CW'(PRESCALE - 1);
    else                    cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/wash_cycle_controller.sv
// Washer sequencer: power/config front end, fill-wash-drain-rinse-dry run with a
// rinse loop, pause/fault hold with resume, and a one-cycle completion pulse.
module wash_cycle_controller
  import wash_pkg::*;
#(
  parameter int TW          = 10,
  parameter int PRESCALE    = 1,
  parameter int NUM_RINSE   = 1,
  parameter int FILL_T      = 10,
  parameter int RINSE_T     = 30,
  parameter int DRAIN_T     = 10,
  parameter int DRY_T       = 30,
  parameter int MIN_MANUAL  = 120,
  parameter int CFG_TIMEOUT = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          power_toggle,
  input  logic          configu,
  input  logic [2:0]    mode,
  input  logic [TW-1:0] manual_timer,
  input  logic          manual_valid,
  input  logic          run,
  input  logic          pause,
  input  logic          door_error,
  input  logic          water_error,
  output logic [3:0]    state,
  output logic [TW-1:0] time_left,
  output logic [1:0]    error_code,
  output logic          power_on,
  output logic          busy,
  output logic          cycle_done
);
  localparam int TAIL = NUM_RINSE * (FILL_T + RINSE_T + DRAIN_T) + DRAIN_T + DRY_T;

  logic [3:0]    state_q, state_d, resume_q, resume_d;
  logic [TW-1:0] time_q, time_d, phase_q, phase_d, tmo_q, tmo_d, t_q, t_d;
  logic [1:0]    rinse_q, rinse_d, err_q, err_d;
  logic          pwr_q, pwr_d;
  logic          tick, tick_clr, pwr_off, run_phase, wet_phase, phase_end, hold;
  logic [TW-1:0] wash_len;

  wash_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (tick_clr),
    .tick_o (tick)
  );

  assign run_phase = state_q inside {ST_FILL, ST_WASH, ST_RINSE, ST_DRAIN, ST_DRY};
  assign wet_phase = state_q inside {ST_FILL, ST_WASH, ST_RINSE};
  assign phase_end = run_phase && tick && (phase_q <= TW'(1));
  assign hold      = door_error || (water_error && wet_phase) || pause;
  assign wash_len  = t_q - TW'(FILL_T) - TW'(TAIL);
  assign tick_clr  = !pwr_q || pwr_off;

  always_comb begin
    state_d  = state_q;
    resume_d = resume_q;
    time_d   = time_q;
    phase_d  = phase_q;
    tmo_d    = tmo_q;
    t_d      = t_q;
    rinse_d  = rinse_q;
    err_d    = err_q;
    pwr_d    = pwr_q;
    pwr_off  = 1'b0;

    case (state_q)
      ST_IDLE: if (pwr_q) state_d = ST_OPTIONS;
      ST_OPTIONS: begin
        if (configu) begin
          state_d = ST_CONFIG;
          tmo_d   = TW'(CFG_TIMEOUT);
        end else begin
          t_d     = TW'(mode_time(mode));
          time_d  = TW'(mode_time(mode));
          state_d = ST_READY;
        end
      end
      ST_CONFIG: begin
        if (manual_valid && manual_timer >= TW'(MIN_MANUAL)) begin
          t_d     = manual_timer;
          time_d  = manual_timer;
          err_d   = ERR_NONE;
          state_d = ST_READY;
        end else begin
          if (manual_valid) err_d = ERR_MANUAL;
          if (tick) begin
            if (tmo_q <= TW'(1)) pwr_off = 1'b1;
            else                 tmo_d   = tmo_q - 1'b1;
          end
        end
      end
      ST_READY: if (run) state_d = ST_CHECK;
      ST_CHECK: begin
        if (door_error)       err_d = ERR_DOOR;
        else if (water_error) err_d = ERR_WATER;
        else begin
          err_d   = ERR_NONE;
          state_d = ST_FILL;
          phase_d = TW'(FILL_T);
          rinse_d = '0;
        end
      end
      ST_FILL, ST_WASH, ST_RINSE, ST_DRAIN, ST_DRY: begin
        if (tick) begin
          if (time_q != '0)  time_d  = time_q - 1'b1;
          if (phase_q != '0) phase_d = phase_q - 1'b1;
        end
        if (phase_end) begin
          case (state_q)
            ST_FILL: begin
              if (rinse_q == '0) begin
                state_d = ST_WASH;
                phase_d = wash_len;
              end else begin
                state_d = ST_RINSE;
                phase_d = TW'(RINSE_T);
              end
            end
            ST_WASH, ST_RINSE: begin
              state_d = ST_DRAIN;
              phase_d = TW'(DRAIN_T);
            end
            ST_DRAIN: begin
              if (rinse_q < 2'(NUM_RINSE)) begin
                rinse_d = rinse_q + 1'b1;
                state_d = ST_FILL;
                phase_d = TW'(FILL_T);
              end else begin
                state_d = ST_DRY;
                phase_d = TW'(DRY_T);
              end
            end
            default: state_d = ST_DONE;
          endcase
        end
        // a hold taken on a phase-end tick resumes into the phase that follows
        if (hold) begin
          resume_d = state_d;
          state_d  = ST_PAUSED;
          if (door_error)                    err_d = ERR_DOOR;
          else if (water_error && wet_phase) err_d = ERR_WATER;
        end
      end
      ST_PAUSED: begin
        if (run && !door_error && !water_error) begin
          state_d = resume_q;
          err_d   = ERR_NONE;
        end
      end
      ST_DONE: pwr_off = 1'b1;
      default: state_d = ST_IDLE;
    endcase

    if (power_toggle) begin
      if (pwr_q) pwr_off = 1'b1;
      else       pwr_d   = 1'b1;
    end

    if (pwr_off) begin
      state_d  = ST_IDLE;
      resume_d = ST_IDLE;
      pwr_d    = 1'b0;
      time_d   = '0;
      phase_d  = '0;
      tmo_d    = '0;
      t_d      = '0;
      rinse_d  = '0;
      err_d    = ERR_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      resume_q <= ST_IDLE;
      time_q   <= '0;
      phase_q  <= '0;
      tmo_q    <= '0;
      t_q      <= '0;
      rinse_q  <= '0;
      err_q    <= '0;
      pwr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      time_q   <= time_d;
      phase_q  <= phase_d;
      tmo_q    <= tmo_d;
      t_q      <= t_d;
      rinse_q  <= rinse_d;
      err_q    <= err_d;
      pwr_q    <= pwr_d;
    end
  end

  assign state      = state_q;
  assign time_left  = time_q;
  assign error_code = err_q;
  assign power_on   = pwr_q;
  assign busy       = run_phase || (state_q == ST_PAUSED);
  assign cycle_done = (state_q == ST_DONE);

endmodule
